// File: rtl/n64_console.sv
// n64_console: Joybus host that polls an N64 controller with the 0x01 status command.
// Optional N64_CONSOLE_PROBE_EN: send identify (0x00) while no controller is present.
module n64_console #(
  parameter int CLKS_PER_US      = 16,
  parameter int POLL_INTERVAL_US = 16667,
  parameter int TIMEOUT_US       = 100
) (
  input  logic        sample_clk,
  input  logic        rst,
  input  logic        data_rx,
  output logic        data_tx,
  output logic        cur_operation,
  output logic [15:0] button_state,
  output logic [15:0] stick_state,
  output logic        valid,
  output logic        timeout_err,
  output logic        controller_present
);
  localparam int U        = CLKS_PER_US;
  localparam int INTERVAL = POLL_INTERVAL_US * U;
  localparam int TMO      = TIMEOUT_US * U;
  localparam int M1       = (INTERVAL > TMO) ? INTERVAL : TMO;
  localparam int MAXC     = (M1 > 4 * U) ? M1 : 4 * U;
  localparam int CW       = $clog2(MAXC + 1);

  localparam logic [CW-1:0] C_ONE      = CW'(1);
  localparam logic [CW-1:0] C_INTERVAL = CW'(INTERVAL - 1);
  localparam logic [CW-1:0] C_CELL     = CW'(4 * U - 1);
  localparam logic [CW-1:0] C_STOP     = CW'(U - 1);
  localparam logic [CW-1:0] C_TMO      = CW'(TMO - 1);
  localparam logic [CW-1:0] C_SAMPLE   = CW'(2 * U - 1);
  localparam logic [CW-1:0] C_HI0      = CW'(U);
  localparam logic [CW-1:0] C_HI1      = CW'(3 * U);

  typedef enum logic [2:0] {
    S_WAIT,
    S_TX_BIT,
    S_TX_STOP,
    S_RX_WAIT,
    S_RX_SAMPLE,
    S_RX_STOP,
    S_ABORT
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]  bit_q, bit_d;
  logic [31:0] shift_q, shift_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        arm_q, arm_d;
  logic        stop_fell_q, stop_fell_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        data_tx_q, data_tx_d;
  logic        cur_op_q, cur_op_d;
  logic [15:0] button_q, button_d;
  logic [15:0] stick_q, stick_d;
  logic        valid_q, valid_d;
  logic        tmo_err_q, tmo_err_d;
  logic        present_q, present_d;

  logic        fall, rise, tx_bit;
  logic [CW-1:0] high_len;
  logic [5:0]  last_bit;
  logic [7:0]  next_cmd;

  assign fall = rx_prev_q & ~rx_s2_q;
  assign rise = ~rx_prev_q & rx_s2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    cmd_d       = cmd_q;
    arm_d       = arm_q;
    stop_fell_d = stop_fell_q;
    data_tx_d   = data_tx_q;
    cur_op_d    = cur_op_q;
    button_d    = button_q;
    stick_d     = stick_q;
    valid_d     = 1'b0;
    tmo_err_d   = tmo_err_q;
    present_d   = present_q;

    tx_bit   = cmd_q[~bit_q[2:0]];
    high_len = tx_bit ? C_HI1 : C_HI0;
`ifdef N64_CONSOLE_PROBE_EN
    next_cmd = present_q ? 8'h01 : 8'h00;
    last_bit = (cmd_q == 8'h00) ? 6'd23 : 6'd31;
`else
    next_cmd = 8'h01;
    last_bit = 6'd31;
`endif

    case (state_q)
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d   = S_TX_BIT;
          cnt_d     = C_CELL;
          bit_d     = 6'd0;
          cmd_d     = next_cmd;
          cur_op_d  = 1'b1;
          data_tx_d = 1'b0;
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end

      // Each cell starts low; the line rises once the down-counter drops below the high time.
      S_TX_BIT: begin
        if (cnt_q == '0) begin
          data_tx_d = 1'b0;
          if (bit_q == 6'd7) begin
            state_d = S_TX_STOP;
            cnt_d   = C_STOP;
          end else begin
            bit_d = bit_q + 6'd1;
            cnt_d = C_CELL;
          end
        end else begin
          cnt_d     = cnt_q - C_ONE;
          data_tx_d = (cnt_d >= high_len) ? 1'b0 : 1'b1;
        end
      end

      S_TX_STOP: begin
        if (cnt_q == '0) begin
          state_d   = S_RX_WAIT;
          data_tx_d = 1'b1;
          cur_op_d  = 1'b0;
          cnt_d     = C_TMO;
          bit_d     = 6'd0;
          arm_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end

      // arm_q masks an edge that was already in the synchronizer on release.
      S_RX_WAIT: begin
        arm_d = 1'b1;
        if (arm_q && fall) begin
          state_d = S_RX_SAMPLE;
          cnt_d   = C_SAMPLE;
        end else if (cnt_q == '0) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end

      S_RX_SAMPLE: begin
        if (cnt_q == '0) begin
          shift_d = {shift_q[30:0], rx_s2_q};
          bit_d   = bit_q + 6'd1;
          cnt_d   = C_TMO;
          if (bit_q == last_bit) begin
            state_d     = S_RX_STOP;
            stop_fell_d = 1'b0;
          end else begin
            state_d = S_RX_WAIT;
          end
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end

      S_RX_STOP: begin
        if (!stop_fell_q) begin
          if (fall) begin
            stop_fell_d = 1'b1;
            cnt_d       = C_TMO;
          end else if (cnt_q == '0) begin
            state_d = S_ABORT;
          end else begin
            cnt_d = cnt_q - C_ONE;
          end
        end else if (rise) begin
          state_d = S_WAIT;
          cnt_d   = C_INTERVAL;
`ifdef N64_CONSOLE_PROBE_EN
          if (cmd_q == 8'h00) begin
            if (shift_q[23:8] == 16'h0500) begin
              present_d = 1'b1;
              tmo_err_d = 1'b0;
            end else begin
              tmo_err_d = 1'b1;
            end
          end else begin
            button_d  = shift_q[31:16];
            stick_d   = shift_q[15:0];
            valid_d   = 1'b1;
            tmo_err_d = 1'b0;
            present_d = 1'b1;
          end
`else
          button_d  = shift_q[31:16];
          stick_d   = shift_q[15:0];
          valid_d   = 1'b1;
          tmo_err_d = 1'b0;
          present_d = 1'b1;
`endif
        end else if (cnt_q == '0) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end

      S_ABORT: begin
        state_d   = S_WAIT;
        cnt_d     = C_INTERVAL;
        tmo_err_d = 1'b1;
        present_d = 1'b0;
      end

      default: begin
        state_d = S_WAIT;
        cnt_d   = C_INTERVAL;
      end
    endcase
  end

  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_WAIT;
      cnt_q       <= C_INTERVAL;
      bit_q       <= 6'd0;
      shift_q     <= 32'd0;
      cmd_q       <= 8'h01;
      arm_q       <= 1'b0;
      stop_fell_q <= 1'b0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      data_tx_q   <= 1'b1;
      cur_op_q    <= 1'b0;
      button_q    <= 16'd0;
      stick_q     <= 16'd0;
      valid_q     <= 1'b0;
      tmo_err_q   <= 1'b0;
      present_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      cmd_q       <= cmd_d;
      arm_q       <= arm_d;
      stop_fell_q <= stop_fell_d;
      rx_s1_q     <= data_rx;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      data_tx_q   <= data_tx_d;
      cur_op_q    <= cur_op_d;
      button_q    <= button_d;
      stick_q     <= stick_d;
      valid_q     <= valid_d;
      tmo_err_q   <= tmo_err_d;
      present_q   <= present_d;
    end
  end

  assign data_tx            = data_tx_q;
  assign cur_operation      = cur_op_q;
  assign button_state       = button_q;
  assign stick_state        = stick_q;
  assign valid              = valid_q;
  assign timeout_err        = timeout_err_w();
  assign controller_present = present_q;

  function automatic logic timeout_err_w();
    return tmo_err_q;
  endfunction
endmodule
